seq_branch_predictor: RTL
=========================

# seq_branch_predictor

Fetch-stage branch target predictor: the producer of the guessed next PC that the execute-stage branch resolver checks, and the consumer of that resolver's outcome. Holds a direct-mapped branch target buffer with 2-bit saturating counters. Lookup is combinational from the fetch PC. Training happens on the clock edge from resolved-branch feedback. Also keeps saturating prediction and mispredict statistics counters.

## Interface
- ADDR_BIT, 10, instruction-memory address width (word address)
- IDX_BIT, 4, table index width; 2^IDX_BIT entries
- STAT_BIT, 32, statistics counter width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- if_pc  in  ADDR_BIT  PC being fetched
- if_pc_4  in  ADDR_BIT  sequential successor of if_pc
- pc_guessed  out  ADDR_BIT  predicted next PC (combinational)
- pred_hit  out  1  if_pc matched a valid entry (combinational)
- flush  in  1  invalidate all entries
- upd_en  in  1  a resolved instruction is presented this cycle
- upd_pc  in  ADDR_BIT  PC of the resolved instruction
- upd_is_branch  in  1  conditional branch (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ)
- upd_is_jump  in  1  unconditional jump (J26 or J32 register jump)
- upd_taken  in  1  resolver's branched flag
- upd_target  in  ADDR_BIT  resolver's remote target (taken target / jump target)
- upd_pred_succ  in  1  resolver's guessed == actual flag
- stat_total  out  STAT_BIT  count of resolved branches + jumps
- stat_miss  out  STAT_BIT  count of those with upd_pred_succ = 0

## Operation
- Entry fields: valid, tag (ADDR_BIT-IDX_BIT bits), target (ADDR_BIT), is_jump, ctr (2 bits).
- Index = pc[IDX_BIT-1:0]; tag = pc[ADDR_BIT-1:IDX_BIT].
- Lookup: pred_hit = valid[idx] && tag match. pc_guessed = target when pred_hit && (is_jump || ctr[1]); otherwise if_pc_4.
- Update (upd_en=1, flush=0), indexed by upd_pc. upd_is_jump has precedence over upd_is_branch:
  - Jump: write valid=1, tag, target=upd_target, is_jump=1, ctr=11 regardless of hit.
  - Branch, hit: ctr saturating +1 if upd_taken, otherwise saturating -1 (floor 00, ceiling 11). If upd_taken, also write target=upd_target and is_jump=0.
  - Branch, miss, taken: allocate (overwrite) with valid=1, tag, target=upd_target, is_jump=0, ctr=10.
  - Branch, miss, not taken: no table change.
  - Neither flag set: no table change, no stat change.
- Stats: when upd_en && (is_branch || is_jump), stat_total +1. If also !upd_pred_succ, stat_miss +1. Both saturate at all-ones. They count even when flush is high. flush does not clear them.
- flush: all valid cleared on the edge. flush wins over a same-cycle table update.

## Timing
- Lookup: zero latency; pc_guessed and pred_hit follow if_pc / if_pc_4 within the same cycle.
- Update: written at the rising edge; visible to lookup from the next cycle. A same-cycle lookup of the updated index sees the old contents (no bypass).
- Reset (async, any time including mid-update):
  - all valid=0, ctr=01, target=0, tag=0, is_jump=0, stats=0.
  - Hence pred_hit=0 and pc_guessed=if_pc_4 immediately.
- No handshake: upd_en is a single-cycle qualifier. Back-to-back updates to the same index apply in order, one per cycle.

## Test plan
- Reset then lookup if_pc=0x025, if_pc_4=0x026 -> pred_hit=0, pc_guessed=0x026, stat_total=0, stat_miss=0.
- Branch training on upd_pc=0x025, target 0x040:
  - Taken, upd_pred_succ=0 -> next cycle pred_hit=1, pc_guessed=0x040, stat_miss=1.
  - Two not-taken updates -> ctr 10→01→00, pc_guessed=0x026.
  - One taken -> ctr=01, still 0x026.
  - Second taken -> ctr=10, 0x040.
- Aliasing: jump upd_pc=0x035, target 0x100 (same idx 5, tag 0x03) -> lookup 0x025 gives pred_hit=0, pc_guessed=0x026; lookup 0x035 gives 0x100.
- Flush + update same cycle:
  - Flush with upd_en=1 jump at 0x011 -> next cycle all lookups miss.
  - stat_total still increments.
- Saturation: with STAT_BIT=4, 17 mispredicted branch updates -> stat_total=stat_miss=15.
- Async reset asserted mid-cycle after trained entries -> pred_hit drops to 0 before next edge; stats read 0.

Source files
------------

// File: rtl/seq_branch_predictor.sv
// seq_branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup, edge-trained, with saturating stats
module seq_branch_predictor #(
   parameter int ADDR_BIT = 10,
   parameter int IDX_BIT  = 4,
   parameter int STAT_BIT = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_BIT-1:0] if_pc,
   input  logic [ADDR_BIT-1:0] if_pc_4,
   output logic [ADDR_BIT-1:0] pc_guessed,
   output logic                pred_hit,
   input  logic                flush,
   input  logic                upd_en,
   input  logic [ADDR_BIT-1:0] upd_pc,
   input  logic                upd_is_branch,
   input  logic                upd_is_jump,
   input  logic                upd_taken,
   input  logic [ADDR_BIT-1:0] upd_target,
   input  logic                upd_pred_succ,
   output logic [STAT_BIT-1:0] stat_total,
   output logic [STAT_BIT-1:0] stat_miss
);
   localparam int N       = 1 << IDX_BIT;
   localparam int TAG_BIT = ADDR_BIT - IDX_BIT;
   logic [N-1:0]          valid_q, valid_d, jump_q, jump_d;
   logic [TAG_BIT-1:0]    tag_q [N];
   logic [TAG_BIT-1:0]    tag_d [N];
   logic [ADDR_BIT-1:0]   target_q [N];
   logic [ADDR_BIT-1:0]   target_d [N];
   logic [1:0]            ctr_q [N];
   logic [1:0]            ctr_d [N];
   logic [STAT_BIT-1:0]   stat_total_q, stat_total_d, stat_miss_q, stat_miss_d;
   logic [IDX_BIT-1:0]    if_idx, upd_idx;
   logic [TAG_BIT-1:0]    if_tag, upd_tag;
   logic                  upd_hit, is_ctl;
   assign if_idx  = if_pc[IDX_BIT-1:0];
   assign if_tag  = if_pc[ADDR_BIT-1:IDX_BIT];
   assign upd_idx = upd_pc[IDX_BIT-1:0];
   assign upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT];
   assign upd_hit = valid_q[upd_idx] && tag_q[upd_idx] == upd_tag;
   assign is_ctl  = upd_en && (upd_is_branch || upd_is_jump);
   assign pred_hit   = valid_q[if_idx] && tag_q[if_idx] == if_tag;
   assign pc_guessed = pred_hit && (jump_q[if_idx] || ctr_q[if_idx][1]) ? target_q[if_idx] : if_pc_4;
   assign stat_total = stat_total_q;
   assign stat_miss  = stat_miss_q;
   always_comb begin
      valid_d  = valid_q;
      jump_d   = jump_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_en && upd_is_jump) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = upd_tag;
         target_d[upd_idx] = upd_target;
         jump_d[upd_idx]   = 1'b1;
         ctr_d[upd_idx]    = 2'b11;
      end else if (upd_en && upd_is_branch && upd_hit) begin
         ctr_d[upd_idx] = upd_taken ? (ctr_q[upd_idx] == 2'b11 ? 2'b11 : ctr_q[upd_idx] + 2'd1)
                                    : (ctr_q[upd_idx] == 2'b00 ? 2'b00 : ctr_q[upd_idx] - 2'd1);
         if (upd_taken) begin
            target_d[upd_idx] = upd_target;
            jump_d[upd_idx]   = 1'b0;
         end
      end else if (upd_en && upd_is_branch && upd_taken) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = upd_tag;
         target_d[upd_idx] = upd_target;
         jump_d[upd_idx]   = 1'b0;
         ctr_d[upd_idx]    = 2'b10;
      end
      // flush beats any same-cycle training
      if (flush) valid_d = '0;
   end
   always_comb begin
      stat_total_d = is_ctl && ~&stat_total_q ? stat_total_q + 1'b1 : stat_total_q;
      stat_miss_d  = is_ctl && !upd_pred_succ && ~&stat_miss_q ? stat_miss_q + 1'b1 : stat_miss_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= '0;
         jump_q       <= '0;
         stat_total_q <= '0;
         stat_miss_q  <= '0;
         for (int i = 0; i < N; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q      <= valid_d;
         jump_q       <= jump_d;
         tag_q        <= tag_d;
         target_q     <= target_d;
         ctr_q        <= ctr_d;
         stat_total_q <= stat_total_d;
         stat_miss_q  <= stat_miss_d;
      end
   end
endmodule
